// File: rtl/mem_resp_sram.sv
// Word-organised SRAM responder for CPU load/store/fetch requests with RV32 sizing and programmable latency.
// Optional MEM_MISALIGN_CHK_EN: misaligned h/w accesses fault instead of being force-aligned.
module mem_resp_sram #(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_i,
   input  logic [2:0]  req_func3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q, wdata_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          accept, commit, we;

   logic          c_wr;
   logic [2:0]    c_f3;
   logic [31:0]   c_addr, c_wdata, off;
   logic          in_rng, f3_bad, mis, is_h, is_w;
   logic [1:0]    lane;
   logic [ADDR_W-1:0] idx;
   logic [3:0][7:0]   rword, wword;
   logic [3:0]    be;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;

   logic [3:0][7:0] mem [DEPTH];

   assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
   assign accept       = req_valid_i && req_ready_o;
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

   // With LATENCY==1 the commit edge is the accept edge, so decode the live inputs in IDLE.
   assign c_wr    = (state_q == S_IDLE) ? req_wr_i    : wr_q;
   assign c_f3    = (state_q == S_IDLE) ? req_func3_i : f3_q;
   assign c_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
   assign c_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            if (LATENCY == 1) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP: if (resp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      off    = c_addr - BASE_ADDR;
      in_rng = (c_addr >= BASE_ADDR) && ((off >> (ADDR_W + 2)) == 32'd0);
      f3_bad = (c_f3 inside {3'b011, 3'b110, 3'b111}) || (c_wr && c_f3[2]);
      is_h   = (c_f3[1:0] == 2'b01);
      is_w   = (c_f3[1:0] == 2'b10);
`ifdef MEM_MISALIGN_CHK_EN
      mis    = (is_h && off[0]) || (is_w && (off[1:0] != 2'b00));
      lane   = off[1:0];
`else
      mis    = 1'b0;
      lane   = is_w ? 2'b00 : {off[1], is_h ? 1'b0 : off[0]};
`endif
      err_d  = !in_rng || f3_bad || mis;
      idx    = off[ADDR_W+1:2];
      rword  = mem[idx];
      rbyte  = rword[lane];
      rhalf  = lane[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};

      rdata_d = 32'd0;
      if (!err_d && !c_wr) begin
         case (c_f3[1:0])
            2'b00:   rdata_d = c_f3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   rdata_d = c_f3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: rdata_d = rword;
         endcase
      end

      case (c_f3[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wword = {4{c_wdata[7:0]}};
         end
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{c_wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wword = c_wdata;
         end
      endcase
      we = commit && c_wr && !err_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= req_wr_i;
            f3_q    <= req_func3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (commit) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   // Array is never reset so it maps onto plain SRAM with byte enables.
   always_ff @(posedge clk_i) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][b] <= wword[b];
         end
      end
   end
endmodule

// File: tb/tb_mem_resp_sram.sv
// Randomized bench for mem_resp_sram against a byte-addressed reference model.
module tb_mem_resp_sram;
   localparam int          LAT   = 2;
   localparam int          AW    = 16;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam longint      DEPTH = 64'd1 << AW;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
   logic [2:0]  req_func3 = 3'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        resp_valid, resp_ready = 1'b0, resp_err;
   logic [31:0] resp_rdata;

   int nchk = 0, nerr = 0;
   logic [7:0] mref [longint];

   mem_resp_sram #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_wr_i(req_wr), .req_func3_i(req_func3), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata), .resp_err_o(resp_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Architectural view: flat byte memory, sized accesses, extension by arithmetic.
   function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      longint off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
      int sz = 1 << f3[1:0];
      logic [31:0] v = 32'd0;
      err = (off < 0) || (off >= 4 * DEPTH) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
            || (wr && f3[2]);
`ifdef MEM_MISALIGN_CHK_EN
      if (off % sz != 0) err = 1'b1;
`else
      off = off - (off % sz);
`endif
      rd = 32'd0;
      if (err) return;
      if (wr) begin
         for (int i = 0; i < sz; i++) mref[off + i] = wd[8*i +: 8];
         return;
      end
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mref.exists(off + i) ? mref[off + i] : 8'h00;
      if (!f3[2] && sz < 4 && v[8*sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      rd = v;
   endfunction

   task automatic xact(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output bit er);
      logic [31:0] erd;
      bit eer;
      int n;
      rd = 32'd0;
      er = 1'b0;
      model(wr, f3, addr, wd, erd, eer);
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_func3 = f3; req_addr = addr; req_wdata = wd;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_wr = $urandom; req_addr = $urandom; req_func3 = 3'($urandom);
      n = 1;
      while (!resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, LAT);
      rd = resp_rdata;
      er = resp_err;
      chk("rdata", rd, erd);
      chk("err", 32'(er), 32'(eer));
      repeat (hold) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata", resp_rdata, rd);
         chk("bp_err", 32'(resp_err), 32'(er));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("ready_after_release", 32'(req_ready), 32'd1);
      chk("valid_after_release", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, a;
      bit er;
      int sel;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // Preload a 64-word window so every in-window load has known contents
      xact(1'b1, 3'b010, BASE, 32'h0BAD_F00D, 0, rd, er);
      for (int w = 1; w < 64; w++) xact(1'b1, 3'b010, BASE + 32'(4 * w), $urandom, 0, rd, er);

      // Store dropped by reset while waiting
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_func3 = 3'b010; req_addr = BASE;
      req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 3'b010, BASE, 32'd0, 0, rd, er);
      chk("midrst_old", rd, 32'h0BAD_F00D);

      // Sub-word loads
      xact(1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678, 0, rd, er);
      xact(1'b0, 3'b000, 32'h8000_0013, 32'd0, 0, rd, er);  chk("lb13", rd, 32'h12);
      xact(1'b0, 3'b100, 32'h8000_0013, 32'd0, 0, rd, er);  chk("lbu13", rd, 32'h12);
      xact(1'b0, 3'b001, 32'h8000_0012, 32'd0, 0, rd, er);  chk("lh12", rd, 32'h1234);
      xact(1'b0, 3'b101, 32'h8000_0012, 32'd0, 0, rd, er);  chk("lhu12", rd, 32'h1234);

      // Byte store merge and sign extension, with backpressure on one response
      xact(1'b1, 3'b000, 32'h8000_0011, 32'h0000_00FF, 0, rd, er);
      xact(1'b0, 3'b010, 32'h8000_0010, 32'd0, 5, rd, er);  chk("lw_merge", rd, 32'h1234_FF78);
      xact(1'b0, 3'b000, 32'h8000_0011, 32'd0, 0, rd, er);  chk("lb_sext", rd, 32'hFFFF_FFFF);
      xact(1'b0, 3'b100, 32'h8000_0011, 32'd0, 0, rd, er);  chk("lbu_zext", rd, 32'h0000_00FF);

      // Access faults
      xact(1'b0, 3'b010, 32'h7FFF_FFFC, 32'd0, 0, rd, er);  chk("below_base", 32'(er), 32'd1);
      xact(1'b1, 3'b010, BASE + 32'h0004_0000, 32'hCAFE_F00D, 0, rd, er);
      chk("past_end", 32'(er), 32'd1);
      xact(1'b0, 3'b011, 32'h8000_0010, 32'd0, 0, rd, er);  chk("f3_011", 32'(er), 32'd1);
      xact(1'b1, 3'b100, 32'h8000_0010, 32'h55, 0, rd, er); chk("sbu_illegal", 32'(er), 32'd1);
      xact(1'b0, 3'b010, 32'h8000_0010, 32'd0, 0, rd, er);  chk("unchanged", rd, 32'h1234_FF78);

      // Misaligned word
      xact(1'b0, 3'b010, 32'h8000_0002, 32'd0, 0, rd, er);
`ifdef MEM_MISALIGN_CHK_EN
      chk("misalign_err", 32'(er), 32'd1);
`else
      chk("misalign_word", rd, 32'h0BAD_F00D);
`endif

      // Random traffic
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = BASE - 32'($urandom_range(1, 64));
         else if (sel == 1) a = BASE + 32'h0004_0000 + 32'($urandom_range(0, 64));
         else               a = BASE + 32'($urandom_range(0, 255));
         xact(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3), rd, er);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
